// File: rtl/mem_wb_pkg.sv
// Shared types and widths for the MEM->WB forwarding stage.
// Struct field widths follow the package constants below; the stage
// parameters default to the same values and must stay consistent with them.
package mem_wb_pkg;

   localparam int unsigned MW_XLEN = 32;
   localparam int unsigned MW_RD_W = 5;
   localparam int unsigned MW_ID_W = 6;
   localparam int unsigned BE_W    = MW_XLEN / 8;
   localparam int unsigned WADDR_W = MW_XLEN - 2;

   // One WB-bound entry: every registered output field plus the forward flag.
   typedef struct packed {
      logic [MW_RD_W-1:0] rd_addr;
      logic               rd_valid;
      logic [MW_XLEN-1:0] pc;
      logic [MW_XLEN-1:0] exec_out;
      logic [MW_XLEN-1:0] mem_addr;
      logic [MW_ID_W-1:0] instr_id;
      logic [MW_XLEN-1:0] mem_data;
      logic               fwd_hit;
   } wb_entry_t;

   // One recent store, tracked at word granularity.
   typedef struct packed {
      logic               valid;
      logic [WADDR_W-1:0] waddr;
      logic [MW_XLEN-1:0] data;
      logic [BE_W-1:0]    be;
   } sq_entry_t;

endpackage

// File: rtl/mem_wb_store_window.sv
// Recent-store window: shift register of the last SQ_DEPTH stores (index 0 is
// youngest) plus a per-byte-lane youngest-match merge into raw load data.
// Ports: clk, rst (async, active-high), push/push_entry (new store),
// lkp_waddr/lkp_be (load word address and lanes), raw_data (memory data),
// merged_data_c/fwd_hit_c (combinational merge result and any-lane-forwarded).
module mem_wb_store_window
   import mem_wb_pkg::*;
#(
   parameter int unsigned SQ_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  sq_entry_t          push_entry,
   input  logic [WADDR_W-1:0] lkp_waddr,
   input  logic [BE_W-1:0]    lkp_be,
   input  logic [MW_XLEN-1:0] raw_data,
   output logic [MW_XLEN-1:0] merged_data_c,
   output logic               fwd_hit_c
);

   sq_entry_t sq_q [SQ_DEPTH];
   sq_entry_t sq_d [SQ_DEPTH];

   // Shift on push; the oldest entry falls off the end.
   always_comb begin
      sq_d = sq_q;
      if (push) begin
         for (int i = int'(SQ_DEPTH) - 1; i > 0; i--) begin
            sq_d[i] = sq_q[i-1];
         end
         sq_d[0] = push_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SQ_DEPTH); i++) begin
            sq_q[i] <= '0;
         end
      end else begin
         sq_q <= sq_d;
      end
   end

   // Scan oldest to youngest so the youngest matching store wins each lane.
   always_comb begin
      merged_data_c = raw_data;
      fwd_hit_c     = 1'b0;
      for (int b = 0; b < int'(BE_W); b++) begin
         if (lkp_be[b]) begin
            for (int i = int'(SQ_DEPTH) - 1; i >= 0; i--) begin
               if (sq_q[i].valid && (sq_q[i].waddr == lkp_waddr) && sq_q[i].be[b]) begin
                  merged_data_c[b*8 +: 8] = sq_q[i].data[b*8 +: 8];
                  fwd_hit_c               = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/mem_wb_fwd_stage.sv
// MEM->WB pipeline boundary with a 2-entry skid buffer, flush, and
// store-to-load byte forwarding from a window of recent stores.
// Ports: clk, rst (async, active-high), flush; in_* MEM-side entry with
// in_valid/in_ready; out_* registered WB-side entry with out_valid/out_ready;
// out_mem_data is load data after forwarding, out_fwd_hit flags any forwarded
// byte. Optional macro MEM_WB_FWD_CNT_EN adds fwd_count, the number of
// transferred entries with out_fwd_hit set.
module mem_wb_fwd_stage
   import mem_wb_pkg::*;
#(
   parameter int unsigned XLEN     = MW_XLEN,
   parameter int unsigned RD_W     = MW_RD_W,
   parameter int unsigned ID_W     = MW_ID_W,
   parameter int unsigned SQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RD_W-1:0]   in_rd_addr,
   input  logic              in_rd_valid,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_exec_out,
   input  logic [XLEN-1:0]   in_mem_addr,
   input  logic [XLEN-1:0]   in_mem_rdata,
   input  logic [ID_W-1:0]   in_instr_id,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [XLEN-1:0]   in_store_data,
   input  logic [XLEN/8-1:0] in_be,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RD_W-1:0]   out_rd_addr,
   output logic              out_rd_valid,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_exec_out,
   output logic [XLEN-1:0]   out_mem_addr,
   output logic [ID_W-1:0]   out_instr_id,
   output logic [XLEN-1:0]   out_mem_data,
   output logic              out_fwd_hit
`ifdef MEM_WB_FWD_CNT_EN
   ,
   output logic [31:0]       fwd_count
`endif
);

   wb_entry_t main_q, main_d, skid_q, skid_d, in_entry_c;
   logic      main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic      accept_c, xfer_c, push_c;
   sq_entry_t push_entry_c;
   logic [XLEN-1:0] merged_c;
   logic            win_hit_c;

   assign in_ready = !skid_valid_q;
   assign accept_c = in_valid && in_ready;
   assign xfer_c   = main_valid_q && out_ready;
   // An entry accepted in a flush cycle is discarded, including its store.
   assign push_c   = accept_c && in_is_store && !flush;

   assign push_entry_c = '{valid: 1'b1, waddr: in_mem_addr[XLEN-1:2],
                           data: in_store_data, be: in_be};

   mem_wb_store_window #(.SQ_DEPTH(SQ_DEPTH)) u_window (
      .clk           (clk),
      .rst           (rst),
      .push          (push_c),
      .push_entry    (push_entry_c),
      .lkp_waddr     (in_mem_addr[XLEN-1:2]),
      .lkp_be        (in_be),
      .raw_data      (in_mem_rdata),
      .merged_data_c (merged_c),
      .fwd_hit_c     (win_hit_c)
   );

   // Entry as it would be captured this cycle; load+store counts as a store.
   always_comb begin
      in_entry_c          = '0;
      in_entry_c.rd_addr  = in_rd_addr;
      in_entry_c.rd_valid = in_rd_valid;
      in_entry_c.pc       = in_pc;
      in_entry_c.exec_out = in_exec_out;
      in_entry_c.mem_addr = in_mem_addr;
      in_entry_c.instr_id = in_instr_id;
      in_entry_c.mem_data = in_mem_rdata;
      if (in_is_load && !in_is_store) begin
         in_entry_c.mem_data = merged_c;
         in_entry_c.fwd_hit  = win_hit_c;
      end
   end

   // Main/skid next state; flush beats transfer and accept.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (main_valid_q && !xfer_c) begin
         if (accept_c) begin
            skid_d       = in_entry_c;
            skid_valid_d = 1'b1;
         end
      end else if (skid_valid_q) begin
         main_d       = skid_q;
         main_valid_d = 1'b1;
         skid_valid_d = 1'b0;
      end else if (accept_c) begin
         main_d       = in_entry_c;
         main_valid_d = 1'b1;
      end else begin
         main_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid    = main_valid_q;
   assign out_rd_addr  = main_q.rd_addr;
   assign out_rd_valid = main_q.rd_valid;
   assign out_pc       = main_q.pc;
   assign out_exec_out = main_q.exec_out;
   assign out_mem_addr = main_q.mem_addr;
   assign out_instr_id = main_q.instr_id;
   assign out_mem_data = main_q.mem_data;
   assign out_fwd_hit  = main_q.fwd_hit;

`ifdef MEM_WB_FWD_CNT_EN
   logic [31:0] fwd_count_q, fwd_count_d;

   // Count forwarded transfers; a flush cycle transfers nothing.
   always_comb begin
      fwd_count_d = fwd_count_q;
      if (xfer_c && !flush && main_q.fwd_hit) begin
         fwd_count_d = fwd_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_count_q <= '0;
      end else begin
         fwd_count_q <= fwd_count_d;
      end
   end

   assign fwd_count = fwd_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_fwd_stage.sv
// Scoreboard bench for mem_wb_fwd_stage: directed stimulus pushes expected WB
// entries at accept; a negedge monitor pops and compares on every transfer.
module tb_mem_wb_fwd_stage;
   import mem_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [4:0]  in_rd_addr;
   logic        in_rd_valid;
   logic [31:0] in_pc, in_exec_out, in_mem_addr, in_mem_rdata, in_store_data;
   logic [5:0]  in_instr_id;
   logic        in_is_load, in_is_store;
   logic [3:0]  in_be;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd_addr;
   logic        out_rd_valid;
   logic [31:0] out_pc, out_exec_out, out_mem_addr, out_mem_data;
   logic [5:0]  out_instr_id;
   logic        out_fwd_hit;
`ifdef MEM_WB_FWD_CNT_EN
   logic [31:0] fwd_count;
`endif

   wb_entry_t exp_q[$];
   int checks   = 0;
   int failures = 0;
   logic burst_mode = 1'b0;
   logic ready_low_seen = 1'b0;

   always #5 clk = ~clk;

   mem_wb_fwd_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid), .in_pc(in_pc),
      .in_exec_out(in_exec_out), .in_mem_addr(in_mem_addr), .in_mem_rdata(in_mem_rdata),
      .in_instr_id(in_instr_id), .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_store_data(in_store_data), .in_be(in_be),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd_addr(out_rd_addr), .out_rd_valid(out_rd_valid), .out_pc(out_pc),
      .out_exec_out(out_exec_out), .out_mem_addr(out_mem_addr), .out_instr_id(out_instr_id),
      .out_mem_data(out_mem_data), .out_fwd_hit(out_fwd_hit)
`ifdef MEM_WB_FWD_CNT_EN
      , .fwd_count(fwd_count)
`endif
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endtask

   // Monitor: compare each transfer against the scoreboard and check stall stability.
   wb_entry_t held;
   logic      held_v = 1'b0;
   always @(negedge clk) begin
      wb_entry_t got, e;
      got = '{rd_addr: out_rd_addr, rd_valid: out_rd_valid, pc: out_pc,
              exec_out: out_exec_out, mem_addr: out_mem_addr, instr_id: out_instr_id,
              mem_data: out_mem_data, fwd_hit: out_fwd_hit};
      if (burst_mode && !in_ready) ready_low_seen = 1'b1;
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v && out_valid) begin
            checks++;
            if (got !== held) begin
               failures++;
               $display("FAIL stall_hold: got exec=%h data=%h expected exec=%h data=%h",
                        got.exec_out, got.mem_data, held.exec_out, held.mem_data);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out: got pc=%h exec=%h with empty scoreboard",
                        got.pc, got.exec_out);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  failures++;
                  $display("FAIL out_entry: got pc=%h exec=%h addr=%h data=%h hit=%b rd=%h/%b id=%h expected pc=%h exec=%h addr=%h data=%h hit=%b rd=%h/%b id=%h",
                           got.pc, got.exec_out, got.mem_addr, got.mem_data, got.fwd_hit,
                           got.rd_addr, got.rd_valid, got.instr_id,
                           e.pc, e.exec_out, e.mem_addr, e.mem_data, e.fwd_hit,
                           e.rd_addr, e.rd_valid, e.instr_id);
               end
            end
         end
         held_v = out_valid && !out_ready && !flush;
         held   = got;
      end
   end

   // Offer one entry, wait (bounded) for acceptance, then record its expected WB image.
   task automatic send(input logic [31:0] pc, input logic [31:0] exec, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [31:0] sdata, input logic [3:0] be,
                       input logic ld, input logic st,
                       input logic [31:0] exp_data, input logic exp_hit);
      wb_entry_t e;
      int n;
      in_valid      = 1'b1;
      in_pc         = pc;
      in_exec_out   = exec;
      in_mem_addr   = addr;
      in_mem_rdata  = rdata;
      in_store_data = sdata;
      in_be         = be;
      in_is_load    = ld;
      in_is_store   = st;
      in_rd_addr    = exec[4:0];
      in_rd_valid   = !st;
      in_instr_id   = pc[7:2];
      e = '{rd_addr: exec[4:0], rd_valid: !st, pc: pc, exec_out: exec, mem_addr: addr,
            instr_id: pc[7:2], mem_data: exp_data, fwd_hit: exp_hit};
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stayed 0 for pc=%h", pc);
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic alu(input logic [31:0] exec);
      send(32'h1000 + (exec << 2), exec, 32'h0, 32'hA000_0000 | exec, 32'h0, 4'h0,
           1'b0, 1'b0, 32'hA000_0000 | exec, 1'b0);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      send(32'h2000 + addr, addr, addr, 32'h0, data, be, 1'b0, 1'b1, 32'h0, 1'b0);
   endtask

   task automatic load(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] rdata,
                       input logic [31:0] exp_data, input logic exp_hit);
      send(32'h3000 + addr, addr, addr, rdata, 32'h0, be, 1'b1, 1'b0, exp_data, exp_hit);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rd_addr = '0; in_rd_valid = 1'b0; in_pc = '0; in_exec_out = '0;
      in_mem_addr = '0; in_mem_rdata = '0; in_instr_id = '0; in_is_load = 1'b0;
      in_is_store = 1'b0; in_store_data = '0; in_be = '0;
      #1 rst = 1'b1;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_outputs_zero", 64'(|{out_rd_addr, out_rd_valid, out_pc, out_exec_out,
            out_mem_addr, out_instr_id, out_mem_data, out_fwd_hit}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back ALU ops at full throughput.
      out_ready  = 1'b1;
      burst_mode = 1'b1;
      for (int i = 0; i < 8; i++) alu(32'h10 + 32'(i));
      @(negedge clk);
      check("b2b_last_valid", 64'(out_valid), 64'd1);
      check("b2b_last_exec", 64'(out_exec_out), 64'h17);
      burst_mode = 1'b0;
      check("b2b_in_ready_never_low", 64'(ready_low_seen), 64'd0);
      drain();

      // Backpressure: two entries held, third waits until release.
      out_ready = 1'b0;
      alu(32'h20);
      alu(32'h21);
      @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_head_exec", 64'(out_exec_out), 64'h20);
      @(posedge clk); #1;
      fork
         alu(32'h22);
         begin
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Full-word forward.
      store(32'h100, 32'hDEAD_BEEF, 4'hF);
      load(32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1);
      // Byte merge, youngest store wins per lane.
      store(32'h200, 32'h0000_00AA, 4'h1);
      store(32'h200, 32'h0000_BB00, 4'h2);
      store(32'h200, 32'h0000_00CC, 4'h1);
      load(32'h200, 4'hF, 32'h1122_3344, 32'h1122_BBCC, 1'b1);
      load(32'h200, 4'hC, 32'h1122_3344, 32'h1122_3344, 1'b0);
      load(32'h202, 4'h3, 32'h1122_3344, 32'h1122_BBCC, 1'b1);
      // Eviction: five stores push the first out of a 4-deep window.
      for (int i = 0; i < 5; i++) store(32'h300 + 32'(i * 4), 32'h0BAD_0000 | 32'(i), 4'hF);
      load(32'h300, 4'hF, 32'h0000_5555, 32'h0000_5555, 1'b0);
      load(32'h304, 4'hF, 32'h0000_5555, 32'h0BAD_0001, 1'b1);
      drain();

      // Flush during stall; window survives the flush.
      store(32'h400, 32'hCAFE_F00D, 4'hF);
      drain();
      out_ready = 1'b0;
      alu(32'h30);
      alu(32'h31);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      load(32'h400, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1);
      drain();
`ifdef MEM_WB_FWD_CNT_EN
      check("fwd_count", 64'(fwd_count), 64'd5);
`endif

      // Asynchronous reset mid-stream clears outputs and the window.
      store(32'h500, 32'h1234_5678, 4'hF);
      drain();
      out_ready = 1'b0;
      alu(32'h40);
      #3 rst = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_outputs_zero", 64'(|{out_rd_addr, out_rd_valid, out_pc, out_exec_out,
            out_mem_addr, out_instr_id, out_mem_data, out_fwd_hit}), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      load(32'h500, 4'hF, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_fwd_stage.md
Name: mem_wb_fwd_stage

Overview:
- Parametrised MEM→WB pipeline boundary for the synapse32 core.
- Replaces the fixed free-running register with:
  - a valid/ready handshake using a 2-entry skid buffer;
  - a flush input;
  - a SQ_DEPTH-entry recent-store window that forwards store data into younger loads, byte by byte, with the youngest store winning.
- Sits between the MEM stage / data-memory read port and the WB stage.

Parameters:
- XLEN, 32, datapath and address width.
- RD_W, 5, register-address width.
- ID_W, 6, instruction-id width.
- SQ_DEPTH, 4, number of recent stores tracked (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  drop all buffered entries
- in_valid  in  1  MEM stage offers an entry
- in_ready  out  1  stage can accept
- in_rd_addr  in  RD_W  destination register
- in_rd_valid  in  1  entry writes rd
- in_pc  in  XLEN  instruction PC
- in_exec_out  in  XLEN  ALU result
- in_mem_addr  in  XLEN  load/store address
- in_mem_rdata  in  XLEN  data-memory read data (valid in the in_valid cycle)
- in_instr_id  in  ID_W  decoded instruction id
- in_is_load  in  1  entry is a load
- in_is_store  in  1  entry is a store
- in_store_data  in  XLEN  store data, lane-aligned
- in_be  in  XLEN/8  byte enables of the load/store
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes
- out_rd_addr, out_rd_valid, out_pc, out_exec_out, out_mem_addr, out_instr_id  out  as inputs  registered copies
- out_mem_data  out  XLEN  load data after forwarding merge
- out_fwd_hit  out  1  at least one byte of out_mem_data was forwarded

Behaviour:
- Reset (async): all out_* = 0, out_valid = 0, both skid entries invalid, all window entries invalid; in_ready = 1 after reset.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer when out_valid & out_ready.
  - in_ready = !skid_valid (registered; no combinational path from out_ready).
- Latency 1 cycle when not stalled. Full throughput with out_ready held high.
- Skid buffer:
  - Accept while the main entry holds and is not transferred → capture into skid; in_ready deasserts next cycle.
  - On transfer, skid moves to main.
  - Order is always preserved.
- Flush:
  - Clears main and skid valid the next edge; in_ready = 1 the next cycle.
  - An accept in the flush cycle is discarded.
  - Store window is NOT cleared, because stores reaching this stage have already written memory.
  - Flush has priority over accept and transfer.
- Store window:
  - On accept with in_is_store, push {addr[XLEN-1:2], data, be} at position 0 and shift older entries; the oldest entry falls off when the window is full.
  - Non-store accepts do not touch the window.
  - in_is_load & in_is_store together is illegal; treat the entry as a store.
- Forwarding, on accept with in_is_load:
  - For each byte lane b with in_be[b], take the byte from the youngest valid window entry whose word address matches and whose be[b] = 1.
  - Otherwise take in_mem_rdata byte b. Lanes with in_be[b] = 0 pass in_mem_rdata.
  - out_fwd_hit = OR of the forwarded lanes.
  - The merge is computed combinationally at accept and registered with the entry, into skid or main.
  - Window contents at the accept edge are used; a store accepted in the same cycle cannot affect itself.
  - For non-loads, out_mem_data = in_mem_rdata and out_fwd_hit = 0.
- Stall: outputs hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: MEM_WB_FWD_CNT_EN.
- When defined:
  - Add output fwd_count [31:0], counting transfers with out_fwd_hit = 1.
  - Reset 0; wraps at 2^32; flushed entries are not counted.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_wb_pkg:
  - packed struct wb_entry_t (all out_* fields plus fwd_hit);
  - struct sq_entry_t {valid, waddr, data, be};
  - localparam BE_W = XLEN/8.
- Sub-module mem_wb_store_window:
  - shift-register storage plus a per-lane youngest-match priority mux;
  - inputs: push, push entry, lookup address/be, raw data;
  - outputs: merged data and hit.

Test Plan:
- Back-to-back, out_ready = 1: 8 ALU ops with exec_out 0x10..0x17 → out_valid 1 cycle after each accept, values in order, in_ready never low.
- Backpressure: out_ready = 0 for 3 cycles while in_valid = 1 → two entries held, in_ready = 0 from the second cycle; after release, entries emerge in order with no loss and no duplicate.
- Full-word forward: store 0xDEADBEEF @0x100 be = 0xF, then load @0x100 with mem_rdata = 0 → out_mem_data = 0xDEADBEEF, out_fwd_hit = 1.
- Byte merge, youngest wins:
  - sequence: store 0x000000AA be = 0x1 @0x200, then store 0x0000BB00 be = 0x2 @0x200, then store 0x000000CC be = 0x1 @0x200;
  - then load be = 0xF with rdata = 0x11223344 → 0x1122BBCC.
- Window eviction: SQ_DEPTH+1 stores to distinct words, then load of the first address with rdata = 0x5555 → 0x5555, hit = 0.
- Flush and reset: flush during stall → out_valid = 0 next cycle, in_ready = 1, window still forwards; rst asserted mid-stream → all outputs 0 asynchronously and window empty (load after reset gets raw rdata).
